// File: rtl/i2c_reg_ctrl.sv
// Register-file sequencer for the i2c_slave byte interface: pointer, write/read strobes, read prefetch.
// Define I2C_REG_CTRL_AUTOINC_EN to advance the pointer after each written or consumed byte.
module i2c_reg_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        slv_data_out,
    input  logic              slv_r_w,
    input  logic              slv_data_vld,
    input  logic              slv_start,
    input  logic              slv_stop,
    output logic [7:0]        slv_data_in,
    output logic              slv_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_we,
    output logic [7:0]        reg_wdata,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              ovr
);

    typedef enum logic [2:0] {
        IDLE,
        PTR,
        WR,
        RD_FETCH,
        RD_WAIT,
        RD_HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    logic vld_p0, vld_p1, vld_p2;
    logic start_p0, start_p1, start_p2;
    logic stop_p0, stop_p1, stop_p2;
    logic rw_p0, rw_p1;
    logic ev_vld, ev_start, ev_stop;

`ifdef I2C_REG_CTRL_AUTOINC_EN
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return p + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction
`endif

    // _p0/_p1 form the 2-flop synchroniser; _p2 holds the previous synced level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            {vld_p0, vld_p1, vld_p2}       <= '0;
            {start_p0, start_p1, start_p2} <= '0;
            {stop_p0, stop_p1, stop_p2}    <= '0;
            {rw_p0, rw_p1}                 <= '0;
        end else begin
            vld_p0   <= slv_data_vld;
            vld_p1   <= vld_p0;
            vld_p2   <= vld_p1;
            start_p0 <= slv_start;
            start_p1 <= start_p0;
            start_p2 <= start_p1;
            stop_p0  <= slv_stop;
            stop_p1  <= stop_p0;
            stop_p2  <= stop_p1;
            rw_p0    <= slv_r_w;
            rw_p1    <= rw_p0;
        end
    end

    assign ev_vld   = vld_p1 & ~vld_p2;
    assign ev_start = start_p1 & ~start_p2;
    assign ev_stop  = stop_p1 & ~stop_p2;
    assign reg_addr = ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            reg_wdata   <= '0;
            slv_data_in <= '0;
            slv_ready   <= 1'b0;
            ovr         <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
`ifdef I2C_REG_CTRL_AUTOINC_EN
            if (reg_we) begin
                ptr <= ptr_inc(ptr);
            end
`endif
            // A new START wins over any byte event arriving in the same cycle
            if (ev_start) begin
                state     <= PTR;
                ovr       <= 1'b0;
                slv_ready <= 1'b0;
            end else if (ev_stop) begin
                state     <= IDLE;
                slv_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    PTR: begin
                        if (rw_p1) begin
                            state <= RD_FETCH;
                        end else if (ev_vld) begin
                            ptr   <= slv_data_out[ADDR_W-1:0];
                            state <= WR;
                        end
                    end
                    WR: begin
                        if (ev_vld) begin
                            reg_we    <= 1'b1;
                            reg_wdata <= slv_data_out;
                        end
                    end
                    RD_FETCH: begin
                        reg_re <= 1'b1;
                        state  <= RD_WAIT;
                        if (ev_vld) begin
                            ovr <= 1'b1;
                        end
                    end
                    RD_WAIT: begin
                        if (ev_vld) begin
                            ovr <= 1'b1;
                        end
                        // reg_rdata is valid the cycle after the strobe has dropped
                        if (!reg_re) begin
                            slv_data_in <= reg_rdata;
                            slv_ready   <= 1'b1;
                            state       <= RD_HOLD;
                        end
                    end
                    RD_HOLD: begin
                        if (ev_vld) begin
                            slv_ready <= 1'b0;
                            state     <= RD_FETCH;
`ifdef I2C_REG_CTRL_AUTOINC_EN
                            ptr       <= ptr_inc(ptr);
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
